hvsp_op_sequencer: RTL
======================

// Module: hvsp_op_sequencer
// PURPOSE
// Upstream sequencer for the ATtiny13 HVSP frame shifter. Expands one high-level
// operation (flash word read, signature read, low-fuse read, chip erase) into the
// fixed series of 11-bit SDI/SII instruction frames. Hands each frame to the
// shifter, collects the SDO bytes, polls SDO-ready after erase and returns one result.
// PARAMETERS
// ERASE_TIMEOUT  240000  osc cycles to wait for SDO high after erase (20 ms @ 12 MHz)
// PORTS
// osc        in   1   12 MHz clock; all logic on posedge
// rst_n      in   1   synchronous reset, active low
// cmd_valid  in   1   operation request
// cmd_ready  out  1   high only in IDLE; op accepted when cmd_valid&&cmd_ready
// cmd_op     in   2   0=read flash word, 1=read signature, 2=read low fuse, 3=chip erase
// cmd_addr   in   9   flash word address (op0) / signature index in [1:0] (op1)
// rsp_valid  out  1   one-cycle pulse: result ready
// rsp_data   out  16  {hi,lo} result; byte ops use [7:0], [15:8]=0; erase=0
// rsp_err    out  1   erase timeout flag, qualified by rsp_valid
// frm_req    out  1   frame request to shifter; level, held until frm_done
// frm_sdi    out  8   SDI data byte of current frame; stable while frm_req
// frm_sii    out  8   SII instruction byte of current frame; stable while frm_req
// frm_done   in   1   one-cycle pulse: shifter finished frame
// frm_sdo    in   11  SDO bits captured by shifter; output byte = frm_sdo[10:3]
// sdo_pin    in   1   raw, already-synchronised SDO pin level (erase ready poll)
// busy       out  1   high whenever state != IDLE
// BEHAVIOUR
// - Reset: state IDLE, cmd_ready=1, frm_req=0, frm_sdi=frm_sii=0, rsp_valid=0,
//   rsp_data=0, rsp_err=0, busy=0, frame index=0, timeout counter=0.
// - Reset mid-operation: frm_req low on the next edge; sequence abandoned, no rsp_valid.
// - States: IDLE -> ISSUE -> WAIT -> (ISSUE | POLL | RESP); POLL -> RESP; RESP -> IDLE.
// - IDLE: on accept, latch op/addr, index=0, -> ISSUE. cmd_valid in other states ignored.
// - ISSUE: drive frm_sdi/frm_sii from table[op][index], assert frm_req, -> WAIT.
//   frm_req rises the cycle after accept, and the cycle after entering ISSUE thereafter.
// - WAIT: on frm_done drop frm_req; if capture frame store frm_sdo[10:3] into lo/hi;
//   index++; last frame -> RESP (ops 0-2) or POLL (op3); else -> ISSUE.
//   Exactly one idle cycle (frm_req=0) between consecutive frames.
// - frm_done outside WAIT is ignored; frm_sdo sampled only on frm_done in WAIT.
// - Frame tables (SDI/SII, * = capture):
//   op0: 02/4C, A[7:0]/0C, {7'b0,A[8]}/1C, 00/68, 00/6C*lo, 00/78, 00/7C*hi (7 frames)
//   op1: 08/4C, {6'b0,A[1:0]}/0C, 00/68, 00/6C*lo (4); op2: 04/4C, 00/68, 00/6C*lo (3)
//   op3: 80/4C, 00/64, 00/6C (3). Unused cmd_addr bits ignored.
// - POLL: counter counts up from 0 each cycle; sdo_pin==1 -> RESP, rsp_err=0;
//   counter reaches ERASE_TIMEOUT-1 with sdo_pin==0 -> RESP, rsp_err=1.
//   sdo_pin high on the first POLL cycle succeeds immediately.
// - RESP: rsp_valid=1 for exactly one cycle, -> IDLE. rsp_data/rsp_err hold until next
//   accept; cleared to 0 on accept. Latency accept->rsp_valid = sum(frame times)+frames+1.
// TESTING
// - op0, addr 0x1A5, stub returns frm_sdo={8'h3C,3'b0} then {8'hC3,3'b0} -> frames
//   02/4C,A5/0C,01/1C,00/68,00/6C,00/78,00/7C in order; rsp_data=16'hC33C, rsp_err=0.
// - op1 addr 2, capture byte 0x07 -> frames 08/4C,02/0C,00/68,00/6C; rsp_data=16'h0007.
// - op3, sdo_pin rises 500 cycles into POLL -> rsp_valid ~501 cycles after POLL entry, rsp_err=0.
// - op3, sdo_pin stuck 0, ERASE_TIMEOUT=100 -> rsp_valid after 100 POLL cycles, rsp_err=1.
// - cmd_valid held high during op2, plus spurious frm_done in ISSUE -> single op, 3 frames,
//   cmd_ready=0 throughout; one rsp_valid.
// - rst_n low during 4th frame of op0 -> next edge frm_req=0, busy=0, no rsp_valid; new op OK.

Source files
------------

// File: rtl/hvsp_op_sequencer_if.sv
// hvsp_op_sequencer_if: bundles the command/response port and the frame-shifter handshake of the sequencer
interface hvsp_op_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_addr;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        frm_req;
    logic [7:0]  frm_sdi;
    logic [7:0]  frm_sii;
    logic        frm_done;
    logic [10:0] frm_sdo;
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, frm_done, frm_sdo,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, frm_req, frm_sdi, frm_sii
    );
    modport master (
        output cmd_valid, cmd_op, cmd_addr, frm_done, frm_sdo,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, frm_req, frm_sdi, frm_sii
    );
endinterface

// File: rtl/hvsp_op_sequencer.sv
// hvsp_op_sequencer: expands one HVSP operation into ATtiny13 instruction frames and returns its result
module hvsp_op_sequencer #(
    parameter int ERASE_TIMEOUT = 240000
) (
    input  logic                      i_osc,
    input  logic                      i_rst_n,
    input  logic                      i_sdo_pin,
    output logic                      o_busy,
    hvsp_op_sequencer_if.slave        io_bus
);
    localparam int CW = $clog2(ERASE_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ERASE_TIMEOUT - 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, POLL, RESP} state_t;
    state_t        r_state;
    logic [1:0]    r_op;
    logic [8:0]    r_addr;
    logic [2:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_lo;
    logic [7:0]    r_hi;
    logic [7:0]    r_sdi;
    logic [7:0]    r_sii;
    logic          r_req;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [7:0]    w_sdi;
    logic [7:0]    w_sii;
    logic          w_cap_lo;
    logic          w_cap_hi;
    logic          w_last;
    assign io_bus.cmd_ready = (r_state == IDLE);
    assign o_busy           = (r_state != IDLE);
    assign io_bus.frm_req   = r_req;
    assign io_bus.frm_sdi   = r_sdi;
    assign io_bus.frm_sii   = r_sii;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_data  = {r_hi, r_lo};
    assign io_bus.rsp_err   = r_rsp_err;
    // frame table: SDI/SII bytes of the current frame plus capture and last-frame flags
    always_comb begin
        w_sdi    = 8'h00;
        w_sii    = 8'h00;
        w_cap_lo = 1'b0;
        w_cap_hi = 1'b0;
        w_last   = 1'b0;
        case (r_op)
            2'd0: case (r_idx)
                3'd0: begin w_sdi = 8'h02; w_sii = 8'h4C; end
                3'd1: begin w_sdi = r_addr[7:0]; w_sii = 8'h0C; end
                3'd2: begin w_sdi = {7'b0, r_addr[8]}; w_sii = 8'h1C; end
                3'd3: w_sii = 8'h68;
                3'd4: begin w_sii = 8'h6C; w_cap_lo = 1'b1; end
                3'd5: w_sii = 8'h78;
                default: begin w_sii = 8'h7C; w_cap_hi = 1'b1; w_last = 1'b1; end
            endcase
            2'd1: case (r_idx)
                3'd0: begin w_sdi = 8'h08; w_sii = 8'h4C; end
                3'd1: begin w_sdi = {6'b0, r_addr[1:0]}; w_sii = 8'h0C; end
                3'd2: w_sii = 8'h68;
                default: begin w_sii = 8'h6C; w_cap_lo = 1'b1; w_last = 1'b1; end
            endcase
            2'd2: case (r_idx)
                3'd0: begin w_sdi = 8'h04; w_sii = 8'h4C; end
                3'd1: w_sii = 8'h68;
                default: begin w_sii = 8'h6C; w_cap_lo = 1'b1; w_last = 1'b1; end
            endcase
            default: case (r_idx)
                3'd0: begin w_sdi = 8'h80; w_sii = 8'h4C; end
                3'd1: w_sii = 8'h64;
                default: begin w_sii = 8'h6C; w_last = 1'b1; end
            endcase
        endcase
    end
    // operation FSM: accept, issue frames one at a time, poll after erase, pulse the response
    always_ff @(posedge i_osc) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_op        <= 2'd0;
            r_addr      <= 9'd0;
            r_idx       <= 3'd0;
            r_cnt       <= '0;
            r_lo        <= 8'h00;
            r_hi        <= 8'h00;
            r_sdi       <= 8'h00;
            r_sii       <= 8'h00;
            r_req       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: if (io_bus.cmd_valid) begin
                    r_op      <= io_bus.cmd_op;
                    r_addr    <= io_bus.cmd_addr;
                    r_idx     <= 3'd0;
                    r_lo      <= 8'h00;
                    r_hi      <= 8'h00;
                    r_rsp_err <= 1'b0;
                    r_state   <= ISSUE;
                end
                ISSUE: begin
                    r_sdi   <= w_sdi;
                    r_sii   <= w_sii;
                    r_req   <= 1'b1;
                    r_state <= WAIT;
                end
                WAIT: if (io_bus.frm_done) begin
                    r_req       <= 1'b0;
                    r_lo        <= w_cap_lo ? io_bus.frm_sdo[10:3] : r_lo;
                    r_hi        <= w_cap_hi ? io_bus.frm_sdo[10:3] : r_hi;
                    r_idx       <= r_idx + 3'd1;
                    r_cnt       <= '0;
                    r_rsp_valid <= w_last && (r_op != 2'd3);
                    r_state     <= !w_last ? ISSUE : (r_op == 2'd3 ? POLL : RESP);
                end
                POLL: if (i_sdo_pin || r_cnt == LAST_CNT) begin
                    r_rsp_err   <= !i_sdo_pin;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
